// File: rtl/serial_sum_block_if.sv
// Handshake and operand bundle for the bit-serial adder.
interface serial_sum_block_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   out;

    modport master (
        output start, a, b, carry_in,
        input  busy, done, out
    );

    modport slave (
        input  start, a, b, carry_in,
        output busy, done, out
    );
endinterface

// File: rtl/serial_sum_block.sv
// Bit-serial adder: out = a + b + carry_in, one bit per clock, LSB first.
//
// state | meaning
// IDLE  | waiting for start; out holds the last result
// RUN   | one sum bit per edge, WIDTH edges in total
// DONE  | one-cycle done pulse; a new start is accepted here
module serial_sum_block #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    serial_sum_block_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             carry_nxt;
    logic             s_bit;
    logic             accept;
    logic             last;
    logic [WIDTH:0]   out_q;

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // Single full-adder stage; the new sum bit enters at the MSB so that
    // after WIDTH shifts the register holds the sum in natural order.
    always_comb begin
        s_bit     = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        sum_nxt   = {s_bit, sum_sh[WIDTH-1:1]};
    end

    // Next-state decode; a start is honoured in IDLE and in DONE (back-to-back).
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, serial shifting and result update on the final bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            out_q  <= '0;
        end else if (accept) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.carry_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_nxt;
            carry  <= carry_nxt;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                out_q <= {carry_nxt, sum_nxt};
            end
        end
    end

    // Outputs come straight from flops; no input reaches them combinationally.
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.out  = out_q;
endmodule

// File: tb/tb_serial_sum_block.sv
// Scoreboard bench for serial_sum_block: the driver pushes expected results
// with their expected done cycle, the monitor pops and compares on done.
module tb_serial_sum_block;
    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH:0] res;
        int             cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;
    int   done_seen;
    int   pushed;
    exp_t q[$];

    serial_sum_block_if #(.WIDTH(WIDTH)) bus ();

    serial_sum_block #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare result and timing whenever done is presented.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            exp_t e;
            done_seen++;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: done at cycle %0d, required no done", cyc);
            end else begin
                e = q.pop_front();
                fails--;
                fails++;
                if (bus.out !== e.res) begin
                    fails++;
                    $display("FAIL result: out=%h, required %h", bus.out, e.res);
                end
                tests++;
                if (cyc != e.cyc) begin
                    fails++;
                    $display("FAIL done_cycle: done at cycle %0d, required %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Drive a start at the current negedge; acceptance is the next posedge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic ci, input logic [WIDTH:0] res);
        exp_t e;
        bus.start    = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.carry_in = ci;
        e.res = res;
        e.cyc = cyc + 1 + WIDTH;
        q.push_back(e);
        pushed++;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.carry_in = 1'b0;
    endtask

    task automatic wait_done(output int at);
        int n;
        n  = 0;
        at = -1;
        while (bus.done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: no done within %0d cycles, required done", n);
        end else begin
            at = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int at;
        int at1;
        int at2;
        int nbusy;
        cyc          = 0;
        tests        = 0;
        fails        = 0;
        done_seen    = 0;
        pushed       = 0;
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.carry_in = 1'b0;
        idle(3);
        check("reset_busy", {32'd0, bus.busy}, 33'd0);
        check("reset_done", {32'd0, bus.done}, 33'd0);
        check("reset_out", bus.out, 33'd0);
        rst = 1'b1;
        idle(2);

        // 1: 2 + 1, busy for exactly WIDTH cycles
        issue(32'h0000_0002, 32'h0000_0001, 1'b0, 33'h0_0000_0003);
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) break;
            if (bus.busy === 1'b1) nbusy++;
            @(negedge clk);
        end
        check("busy_cycles", 33'(nbusy), 33'd32);
        wait_done(at);
        idle(2);

        // 2: carry out of the top bit
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000);
        wait_done(at);
        idle(2);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
        wait_done(at);
        idle(2);

        // 3: carry_in rippling through every bit
        issue(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 33'h0_8000_0000);
        wait_done(at);
        idle(2);

        // 4: start while busy is ignored
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789);
        idle(9);
        bus.start    = 1'b1;
        bus.a        = 32'hDEAD_BEEF;
        bus.b        = 32'hCAFE_F00D;
        bus.carry_in = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(at);
        idle(40);
        check("ignored_start_out_held", bus.out, 33'h0_2345_6789);

        // 5: asynchronous reset mid-operation
        issue(32'h0000_1000, 32'h0000_2000, 1'b0, 33'h0_0000_3000);
        idle(14);
        #2;
        rst = 1'b0;
        q.delete();
        pushed--;
        #1;
        check("async_rst_busy", {32'd0, bus.busy}, 33'd0);
        check("async_rst_done", {32'd0, bus.done}, 33'd0);
        check("async_rst_out", bus.out, 33'd0);
        idle(2);
        rst = 1'b1;
        idle(40);
        issue(32'd5, 32'd6, 1'b0, 33'd11);
        wait_done(at);
        idle(2);

        // 6: back-to-back start held through DONE
        issue(32'h0000_000A, 32'h0000_0005, 1'b0, 33'h0_0000_000F);
        wait_done(at1);
        issue(32'h0000_0010, 32'h0000_0020, 1'b0, 33'h0_0000_0030);
        wait_done(at2);
        check("back_to_back_spacing", 33'(at2 - at1), 33'd33);
        idle(5);

        check("scoreboard_empty", 33'(q.size()), 33'd0);
        check("done_count", 33'(done_seen), 33'(pushed));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serial_sum_block.md
Name: serial_sum_block

Overview:
- Bit-serial adder: the addition counterpart to the parallel subtraction datapath.
- Computes out = a + b + carry_in one bit per clock, LSB first, through a single registered full-adder stage.
- A start/busy/done handshake lets the ALU sequencer trade area for latency.
- Used where a 32-stage ripple chain is too costly.

Parameters:
WIDTH, 32, operand width in bits; result is WIDTH+1 bits.
CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-low reset (asserted when 0, takes effect immediately, released synchronously to clk).
start  input  1  request; sampled only when busy=0.
a  input  WIDTH  augend; captured on accepted start.
b  input  WIDTH  addend; captured on accepted start.
carry_in  input  1  initial carry; captured on accepted start.
busy  output  1  high while an operation is in progress (RUN state).
done  output  1  one-cycle pulse; out is valid and updated in that cycle.
out  output  WIDTH+1  result: out[WIDTH-1:0] is the sum, out[WIDTH] is the final carry.

Behaviour:
- Reset (rst=0, any time, including mid-operation):
  - State to IDLE; busy=0, done=0, out=0.
  - Internal operand shift registers, carry flop and counter cleared.
  - The in-flight operation is discarded, with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at edge E0 latches a, b, carry_in and sets cnt=0 and carry=carry_in. Next state is RUN.
- RUN:
  - busy=1.
  - Each edge computes s = a_sh[0]^b_sh[0]^carry and carry' = majority(a_sh[0], b_sh[0], carry).
  - s is shifted into the MSB of the sum register; a_sh and b_sh shift right by 1; cnt increments.
  - At the edge where cnt == WIDTH-1, the final bit is processed.
  - Also at that edge: out <= {carry', sum_next}; next state is DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - The next edge returns to IDLE, unless start=1, which is accepted exactly as in IDLE (back-to-back) and goes to RUN.
- Latency:
  - start accepted at edge E0.
  - Bits processed at edges E1..EWIDTH.
  - done high during the cycle after edge EWIDTH.
  - Accepted-start to done = WIDTH cycles; throughput is one result per WIDTH+1 cycles with back-to-back starts.
- start while busy=1: ignored, not queued; operands and result are unaffected.
- Inputs a, b, carry_in may change freely after acceptance; only the latched copies are used.
- out holds its last value in IDLE and RUN. It changes only at the edge entering DONE, or on reset.
- Arithmetic:
  - Unsigned, modulo-free: out = a + b + carry_in exactly, fits in WIDTH+1 bits.
  - Two's-complement callers read the overflow from their own sign bits; the block produces no flags.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Reset release, then start with a=0x00000002, b=0x00000001, carry_in=0 -> busy high for 32 cycles; done pulses 32 cycles after acceptance; out=0x0_00000003.
2. a=0xFFFFFFFF, b=0x00000001, carry_in=0 -> out=0x1_00000000 (carry bit set). Then a=0xFFFFFFFF, b=0xFFFFFFFF, carry_in=1 -> out=0x1_FFFFFFFF.
3. a=0x7FFFFFFF, b=0x00000000, carry_in=1 -> out=0x0_80000000. This checks that carry_in is applied to bit 0 only and ripples through all bits.
4. start pulsed again at cycle 10 of an operation with different operands -> ignored; first result unchanged; exactly one done pulse.
5. rst driven low at cycle 15 of an operation, asynchronously between edges -> busy, done and out go 0 immediately. After release, there is no done until a new start; a fresh 5+6 then gives out=11.
6. start held high through the DONE cycle with new operands 0x10 and 0x20 -> second operation accepted with no idle cycle; second done exactly 33 cycles after the first; out=0x30.
